// File: rtl/cam_table_mgr.sv
// cam_table_mgr: the command-side controller in front of a CAM instance.
// It converts lookup, insert and delete commands into CAM compare and write
// transactions. It keeps an occupancy bitmap of valid entries, allocates the
// lowest free address for each insert, and returns one response per command.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   cmd_*               command channel (valid/ready); op 00 lookup,
//                       01 insert, 10 delete, 11 reserved
//   rsp_*               response channel (valid/ready); status 00 OK,
//                       01 FULL, 10 NOT_FOUND, 11 BAD_OP
//   cam_write_*, cam_select_mask, cam_compare_data
//                       drive the CAM write and compare ports
//   cam_write_busy, cam_match, cam_match_addr, cam_setup
//                       status inputs returned by the CAM
//   occupancy, full     number of valid entries and the table-full flag
module cam_table_mgr #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned ADDR_WIDTH    = 5,
  parameter int unsigned SLICE_WIDTH   = 4,
  parameter int unsigned MATCH_LATENCY = 2,
  parameter int unsigned SLICE_COUNT   = (DATA_WIDTH + SLICE_WIDTH - 1) / SLICE_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [1:0]             cmd_op,
  input  logic [DATA_WIDTH-1:0]  cmd_key,
  input  logic [SLICE_COUNT-1:0] cmd_mask,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic                   rsp_hit,
  output logic [ADDR_WIDTH-1:0]  rsp_addr,
  output logic [1:0]             rsp_status,
  output logic [ADDR_WIDTH-1:0]  cam_write_addr,
  output logic [DATA_WIDTH-1:0]  cam_write_data,
  output logic                   cam_write_delete,
  output logic                   cam_write_enable,
  output logic [SLICE_COUNT-1:0] cam_select_mask,
  input  logic                   cam_write_busy,
  output logic [DATA_WIDTH-1:0]  cam_compare_data,
  input  logic                   cam_match,
  input  logic [ADDR_WIDTH-1:0]  cam_match_addr,
  input  logic                   cam_setup,
  output logic [ADDR_WIDTH:0]    occupancy,
  output logic                   full
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  typedef enum logic [2:0] {IDLE, LOOKUP, WRITE, WRITE_WAIT, RESP} state_t;
  typedef enum logic [1:0] {
    OP_LOOKUP = 2'b00, OP_INSERT = 2'b01, OP_DELETE = 2'b10, OP_BAD = 2'b11
  } op_t;
  typedef enum logic [1:0] {
    ST_OK = 2'b00, ST_FULL = 2'b01, ST_NOT_FOUND = 2'b10, ST_BAD_OP = 2'b11
  } status_t;

  state_t                 state, state_d;
  op_t                    op_q;
  logic [DATA_WIDTH-1:0]  key_q;
  logic [SLICE_COUNT-1:0] mask_q;
  logic [3:0]             cnt;
  logic [DEPTH-1:0]       bitmap;
  logic [ADDR_WIDTH:0]    occ;
  logic [ADDR_WIDTH-1:0]  wr_addr_q;
  logic                   wr_del_q;
  logic                   rsp_hit_q;
  logic [ADDR_WIDTH-1:0]  rsp_addr_q;
  status_t                rsp_status_q;

  logic                   cmd_fire;
  logic                   rsp_load;
  logic                   rsp_hit_d;
  logic [ADDR_WIDTH-1:0]  rsp_addr_d;
  status_t                rsp_status_d;
  logic                   wr_load;
  logic [ADDR_WIDTH-1:0]  wr_addr_d;
  logic                   wr_del_d;
  logic                   bm_set;
  logic                   bm_clr;
  logic [ADDR_WIDTH-1:0]  alloc_addr;
  logic                   alloc_found;

  // The rst term keeps cmd_ready low during reset even if cam_setup is high.
  assign rsp_valid        = (state == RESP);
  assign cmd_ready        = (state == IDLE) & cam_setup & ~rsp_valid & ~rst;
  assign cmd_fire         = cmd_valid & cmd_ready;
  assign rsp_hit          = rsp_hit_q;
  assign rsp_addr         = rsp_addr_q;
  assign rsp_status       = rsp_status_q;
  assign cam_compare_data = key_q;
  assign cam_write_data   = key_q;
  assign cam_select_mask  = mask_q;
  assign cam_write_addr   = wr_addr_q;
  assign cam_write_delete = wr_del_q;
  assign occupancy        = occ;
  assign full             = (occ == (ADDR_WIDTH + 1)'(DEPTH));

  // Lowest-index free entry.
  always_comb begin
    alloc_addr  = '0;
    alloc_found = 1'b0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!alloc_found && !bitmap[ADDR_WIDTH'(i)]) begin
        alloc_addr  = ADDR_WIDTH'(i);
        alloc_found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d          = state;
    rsp_load         = 1'b0;
    rsp_hit_d        = 1'b0;
    rsp_addr_d       = '0;
    rsp_status_d     = ST_OK;
    wr_load          = 1'b0;
    wr_addr_d        = '0;
    wr_del_d         = 1'b0;
    bm_set           = 1'b0;
    bm_clr           = 1'b0;
    cam_write_enable = 1'b0;
    case (state)
      IDLE: begin
        if (cmd_fire) begin
          if (op_t'(cmd_op) == OP_BAD) begin
            state_d      = RESP;
            rsp_load     = 1'b1;
            rsp_status_d = ST_BAD_OP;
          end else begin
            state_d = LOOKUP;
          end
        end
      end
      LOOKUP: begin
        if (cnt == '0) begin
          case (op_q)
            OP_INSERT: begin
              if (cam_match) begin
                state_d    = RESP;
                rsp_load   = 1'b1;
                rsp_hit_d  = 1'b1;
                rsp_addr_d = cam_match_addr;
              end else if (full || !alloc_found) begin
                state_d      = RESP;
                rsp_load     = 1'b1;
                rsp_status_d = ST_FULL;
              end else begin
                state_d   = WRITE;
                wr_load   = 1'b1;
                wr_addr_d = alloc_addr;
              end
            end
            OP_DELETE: begin
              if (cam_match) begin
                state_d   = WRITE;
                wr_load   = 1'b1;
                wr_addr_d = cam_match_addr;
                wr_del_d  = 1'b1;
              end else begin
                state_d      = RESP;
                rsp_load     = 1'b1;
                rsp_status_d = ST_NOT_FOUND;
              end
            end
            default: begin
              state_d      = RESP;
              rsp_load     = 1'b1;
              rsp_hit_d    = cam_match;
              rsp_addr_d   = cam_match ? cam_match_addr : '0;
              rsp_status_d = cam_match ? ST_OK : ST_NOT_FOUND;
            end
          endcase
        end
      end
      WRITE: begin
        if (!cam_write_busy) begin
          cam_write_enable = 1'b1;
          state_d          = WRITE_WAIT;
        end
      end
      WRITE_WAIT: begin
        if (!cam_write_busy) begin
          state_d    = RESP;
          rsp_load   = 1'b1;
          rsp_hit_d  = wr_del_q;
          rsp_addr_d = wr_addr_q;
          bm_set     = ~wr_del_q;
          bm_clr     = wr_del_q;
        end
      end
      RESP: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      op_q         <= OP_LOOKUP;
      key_q        <= '0;
      mask_q       <= '0;
      cnt          <= '0;
      bitmap       <= '0;
      occ          <= '0;
      wr_addr_q    <= '0;
      wr_del_q     <= 1'b0;
      rsp_hit_q    <= 1'b0;
      rsp_addr_q   <= '0;
      rsp_status_q <= ST_OK;
    end else begin
      state <= state_d;
      // cnt counts down the remaining compare cycles; zero means sample now.
      if (cmd_fire) begin
        op_q   <= op_t'(cmd_op);
        key_q  <= cmd_key;
        mask_q <= cmd_mask;
        cnt    <= 4'(MATCH_LATENCY - 1);
      end else if (state == LOOKUP && cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (wr_load) begin
        wr_addr_q <= wr_addr_d;
        wr_del_q  <= wr_del_d;
      end
      if (rsp_load) begin
        rsp_hit_q    <= rsp_hit_d;
        rsp_addr_q   <= rsp_addr_d;
        rsp_status_q <= rsp_status_d;
      end else if (state == RESP && rsp_ready) begin
        rsp_hit_q    <= 1'b0;
        rsp_addr_q   <= '0;
        rsp_status_q <= ST_OK;
      end
      // Count only real bitmap transitions so occupancy can never wrap.
      if (bm_set && !bitmap[wr_addr_q]) begin
        bitmap[wr_addr_q] <= 1'b1;
        occ               <= occ + 1'b1;
      end
      if (bm_clr && bitmap[wr_addr_q]) begin
        bitmap[wr_addr_q] <= 1'b0;
        occ               <= occ - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_cam_table_mgr.sv
// Testbench for cam_table_mgr. A behavioural CAM answers the compare and write
// ports. A reference table predicts each response, which is queued when the
// command is driven and compared when the DUT presents its response.
module tb_cam_table_mgr;

  localparam int DW = 64;
  localparam int AW = 5;
  localparam int SC = 16;
  localparam int ML = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [1:0]    cmd_op = '0;
  logic [DW-1:0] cmd_key = '0;
  logic [SC-1:0] cmd_mask = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic          rsp_hit;
  logic [AW-1:0] rsp_addr;
  logic [1:0]    rsp_status;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic          cam_write_delete;
  logic          cam_write_enable;
  logic [SC-1:0] cam_select_mask;
  logic          cam_write_busy;
  logic [DW-1:0] cam_compare_data;
  logic          cam_match;
  logic [AW-1:0] cam_match_addr;
  logic          cam_setup = 1'b1;
  logic [AW:0]   occupancy;
  logic          full;

  always #5 clk = ~clk;

  cam_table_mgr #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .SLICE_WIDTH(4), .MATCH_LATENCY(ML)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_key(cmd_key), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_hit(rsp_hit),
    .rsp_addr(rsp_addr), .rsp_status(rsp_status),
    .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_select_mask(cam_select_mask), .cam_write_busy(cam_write_busy),
    .cam_compare_data(cam_compare_data), .cam_match(cam_match),
    .cam_match_addr(cam_match_addr), .cam_setup(cam_setup),
    .occupancy(occupancy), .full(full)
  );

  // Behavioural CAM
  logic [DW-1:0] cam_k [32];
  logic          cam_v [32];
  int            busy_cnt = 0;
  int            busy_len = 1;
  logic          busy_force = 1'b0;

  assign cam_write_busy = busy_force | (busy_cnt != 0);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) cam_v[i] <= 1'b0;
      busy_cnt <= 0;
    end else if (cam_write_enable) begin
      cam_v[cam_write_addr] <= !cam_write_delete;
      if (!cam_write_delete) cam_k[cam_write_addr] <= cam_write_data;
      busy_cnt <= busy_len;
    end else if (busy_cnt != 0) begin
      busy_cnt <= busy_cnt - 1;
    end
  end

  always_comb begin
    cam_match      = 1'b0;
    cam_match_addr = '0;
    for (int i = 31; i >= 0; i--) begin
      if (cam_v[i] === 1'b1 && cam_k[i] == cam_compare_data) begin
        cam_match      = 1'b1;
        cam_match_addr = 5'(i);
      end
    end
  end

  // Write-port monitor
  int            wr_count = 0;
  int            en_double = 0;
  logic          prev_en = 1'b0;
  logic [AW-1:0] last_addr = '0;
  logic          last_del = 1'b0;
  logic [DW-1:0] last_data = '0;
  logic [SC-1:0] last_mask = '0;

  always @(posedge clk) begin
    prev_en <= cam_write_enable;
    if (cam_write_enable) begin
      wr_count  <= wr_count + 1;
      last_addr <= cam_write_addr;
      last_del  <= cam_write_delete;
      last_data <= cam_write_data;
      last_mask <= cam_select_mask;
      if (prev_en) en_double <= en_double + 1;
    end
  end

  // Reference table and scoreboard
  typedef struct {
    logic          hit;
    logic [AW-1:0] addr;
    logic [1:0]    status;
    int            writes;
  } exp_t;

  exp_t          exp_q[$];
  logic [DW-1:0] ref_key [32];
  bit            ref_v [32];
  int            ref_occ = 0;
  int            n_checks = 0;
  int            n_fail = 0;

  task automatic check(input logic [63:0] obs, input logic [63:0] expv, input string tag);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic predict(input logic [1:0] op, input logic [DW-1:0] key, output exp_t e);
    int found;
    int free_i;
    found  = -1;
    free_i = -1;
    for (int i = 0; i < 32; i++) begin
      if (found < 0 && ref_v[i] && ref_key[i] == key) found = i;
      if (free_i < 0 && !ref_v[i]) free_i = i;
    end
    e.hit = 1'b0; e.addr = '0; e.status = 2'b00; e.writes = 0;
    case (op)
      2'b00: begin
        if (found >= 0) begin e.hit = 1'b1; e.addr = 5'(found); end
        else e.status = 2'b10;
      end
      2'b01: begin
        if (found >= 0) begin e.hit = 1'b1; e.addr = 5'(found); end
        else if (free_i < 0) e.status = 2'b01;
        else begin
          e.addr = 5'(free_i); e.writes = 1;
          ref_v[free_i] = 1'b1; ref_key[free_i] = key; ref_occ++;
        end
      end
      2'b10: begin
        if (found >= 0) begin
          e.hit = 1'b1; e.addr = 5'(found); e.writes = 1;
          ref_v[found] = 1'b0; ref_occ--;
        end else e.status = 2'b10;
      end
      default: e.status = 2'b11;
    endcase
  endtask

  // Entered and left at a negedge. busy_hold: cycle after accept at which a
  // forced busy is released (0 = none). rdy_hold: cycles rsp_ready stays low
  // after rsp_valid is first seen.
  task automatic run_cmd(input logic [1:0] op, input logic [DW-1:0] key, input logic [SC-1:0] mask,
                         input int busy_hold, input int lat_override, input int rdy_hold,
                         input string tag);
    exp_t e;
    exp_t g;
    int   lat;
    int   wr0;
    int   wc;
    int   exp_lat;
    predict(op, key, e);
    exp_q.push_back(e);
    exp_lat = (lat_override > 0) ? lat_override :
              (op == 2'b11) ? 1 : (e.writes != 0) ? ML + 4 : ML + 1;
    if (busy_hold > 0) busy_force = 1'b1;
    if (rdy_hold > 0) rsp_ready = 1'b0;
    cmd_valid = 1'b1; cmd_op = op; cmd_key = key; cmd_mask = mask;
    #1;
    wc = 0;
    while (!cmd_ready && wc < 50) begin @(negedge clk); #1; wc++; end
    check(64'(cmd_ready), 64'(1), {tag, "/accept"});
    wr0 = wr_count;
    @(negedge clk);
    cmd_valid = 1'b0; cmd_op = '0; cmd_key = '0;
    lat = 1;
    while (lat < 100) begin
      if (busy_hold > 0 && lat == busy_hold) begin
        check(64'(wr_count - wr0), 64'(0), {tag, "/no_enable_while_busy"});
        busy_force = 1'b0;
      end
      #1;
      if (rsp_valid) break;
      @(negedge clk);
      lat++;
    end
    check(64'(lat), 64'(exp_lat), {tag, "/latency"});
    g = exp_q.pop_front();
    check(64'(rsp_hit), 64'(g.hit), {tag, "/hit"});
    check(64'(rsp_addr), 64'(g.addr), {tag, "/addr"});
    check(64'(rsp_status), 64'(g.status), {tag, "/status"});
    if (rdy_hold > 0) begin
      repeat (rdy_hold) begin
        @(negedge clk); #1;
        check(64'({rsp_valid, rsp_hit, rsp_addr, rsp_status, cmd_ready}),
              64'({1'b1, g.hit, g.addr, g.status, 1'b0}), {tag, "/held_stable"});
      end
      rsp_ready = 1'b1;
    end
    @(negedge clk); #1;
    check(64'({rsp_valid, rsp_hit, rsp_addr, rsp_status}), 64'(0), {tag, "/rsp_cleared"});
    check(64'(wr_count - wr0), 64'(g.writes), {tag, "/write_pulses"});
    check(64'(occupancy), 64'(ref_occ), {tag, "/occupancy"});
    check(64'(full), 64'(ref_occ == 32), {tag, "/full"});
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int wr0;
    int wc;
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    check(64'({cmd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_status, cam_write_addr,
               cam_write_delete, cam_write_enable, cam_select_mask, occupancy, full}),
          64'(0), "reset/outputs");
    check(cam_write_data | cam_compare_data, 64'(0), "reset/data");
    rst = 1'b0;
    #1;
    check(64'(cmd_ready), 64'(1), "reset/ready_after_release");
    @(negedge clk);

    // First insert and lookups
    run_cmd(2'b01, 64'h1234, '1, 0, 0, 0, "ins_1234");
    check(64'({last_addr, last_del}), 64'({5'd0, 1'b0}), "ins_1234/write_addr_del");
    check(last_data, 64'h1234, "ins_1234/write_data");
    run_cmd(2'b00, 64'h1234, '1, 0, 0, 0, "lkp_hit");
    run_cmd(2'b00, 64'h5678, '1, 0, 0, 0, "lkp_miss");

    // Fill the table
    for (int i = 1; i < 32; i++) begin
      run_cmd(2'b01, 64'h1000 + 64'(i), '1, 0, 0, 0, "fill");
      check(64'(last_addr), 64'(i), "fill/alloc_order");
    end
    check(64'({full, occupancy}), 64'({1'b1, 6'd32}), "fill/full");
    run_cmd(2'b01, 64'h2000, '1, 0, 0, 0, "ins_when_full");
    run_cmd(2'b01, 64'h1234, '1, 0, 0, 0, "reins_when_full");

    // Delete and reuse
    run_cmd(2'b10, 64'h1005, '1, 0, 0, 0, "del_addr5");
    check(64'({last_addr, last_del, occupancy}), 64'({5'd5, 1'b1, 6'd31}), "del_addr5/write");
    run_cmd(2'b00, 64'h1005, '1, 0, 0, 0, "lkp_deleted");
    run_cmd(2'b01, 64'hABCD, 16'h00FF, 0, 0, 0, "ins_reuse5");
    check(64'({last_addr, last_del, occupancy}), 64'({5'd5, 1'b0, 6'd32}), "ins_reuse5/write");
    check(64'({last_data[15:0], last_mask}), 64'({16'hABCD, 16'h00FF}), "ins_reuse5/data_mask");
    run_cmd(2'b10, 64'h9999, '1, 0, 0, 0, "del_absent");

    // Busy before and after the enable
    busy_len = 3;
    run_cmd(2'b10, 64'h1007, '1, 7, 12, 0, "busy_del");
    busy_len = 1;
    check(64'(en_double), 64'(0), "enable_single_cycle");

    // Back-pressure on the response
    run_cmd(2'b00, 64'h1002, '1, 0, 0, 5, "rsp_backpressure");

    // Reserved opcode
    run_cmd(2'b11, 64'h1234, '1, 0, 0, 0, "bad_op");

    // CAM not set up
    cam_setup = 1'b0;
    cmd_valid = 1'b1; cmd_op = 2'b00; cmd_key = 64'h1234;
    wr0 = wr_count;
    repeat (3) begin
      #1;
      check(64'({cmd_ready, rsp_valid}), 64'(0), "no_setup/stall");
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    cam_setup = 1'b1;
    @(negedge clk);

    // Reset during WRITE_WAIT
    busy_len = 6;
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_key = 64'h7777; cmd_mask = '1;
    #1;
    wc = 0;
    while (!cmd_ready && wc < 50) begin @(negedge clk); #1; wc++; end
    check(64'(cmd_ready), 64'(1), "rst_mid/accept");
    wr0 = wr_count;
    @(negedge clk);
    cmd_valid = 1'b0;
    wc = 0;
    while (wr_count == wr0 && wc < 20) begin @(negedge clk); wc++; end
    check(64'(wr_count - wr0), 64'(1), "rst_mid/enable_seen");
    rst = 1'b1;
    #1;
    check(64'({cmd_ready, rsp_valid, rsp_hit, rsp_addr, rsp_status, cam_write_addr,
               cam_write_delete, cam_write_enable, cam_select_mask, occupancy, full}),
          64'(0), "rst_mid/outputs");
    check(cam_write_data | cam_compare_data, 64'(0), "rst_mid/data");
    wr0 = wr_count;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    #1;
    check(64'({rsp_valid, occupancy}), 64'(0), "rst_mid/after_release");
    check(64'(wr_count - wr0), 64'(0), "rst_mid/no_more_enable");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cam_table_mgr.md
Name: cam_table_mgr

Overview:
- Command-side initiator for the CAM: turns lookup, insert and delete requests into CAM compare and write-port transactions.
- Keeps an occupancy bitmap of valid entries and allocates free addresses for inserts.
- Returns one response per command over a valid/ready handshake.
- Sits between the control datapath and a cam instance; all cam write/compare ports are driven from here.

Parameters:
- DATA_WIDTH, 64, key width; equals the CAM search data width.
- ADDR_WIDTH, 5, CAM depth is 2**ADDR_WIDTH entries.
- SLICE_WIDTH, 4, CAM slice width; SLICE_COUNT = (DATA_WIDTH+SLICE_WIDTH-1)/SLICE_WIDTH.
- MATCH_LATENCY, 2, cycles from the first cycle cam_compare_data is valid to the cycle cam_match/cam_match_addr are sampled; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command valid
- cmd_ready  out  1  command accepted when cmd_valid & cmd_ready
- cmd_op  in  2  00 lookup, 01 insert, 10 delete, 11 reserved
- cmd_key  in  DATA_WIDTH  key
- cmd_mask  in  SLICE_COUNT  slice select mask, used on insert writes
- rsp_valid  out  1  response valid, held until rsp_ready
- rsp_ready  in  1  response consumer ready
- rsp_hit  out  1  key was present before the command executed
- rsp_addr  out  ADDR_WIDTH  matched or allocated address; 0 when not applicable
- rsp_status  out  2  00 OK, 01 FULL, 10 NOT_FOUND, 11 BAD_OP
- cam_write_addr  out  ADDR_WIDTH  to cam write_addr
- cam_write_data  out  DATA_WIDTH  to cam write_data
- cam_write_delete  out  1  to cam write_delete
- cam_write_enable  out  1  to cam write_enable; single-cycle pulse
- cam_select_mask  out  SLICE_COUNT  to cam select_mask
- cam_write_busy  in  1  from cam write_busy
- cam_compare_data  out  DATA_WIDTH  to cam compare_data; registered
- cam_match  in  1  from cam match
- cam_match_addr  in  ADDR_WIDTH  from cam match_addr
- cam_setup  in  1  from cam setup; high = CAM initialised and usable
- occupancy  out  ADDR_WIDTH+1  number of valid entries
- full  out  1  occupancy == 2**ADDR_WIDTH

Behaviour:
- Reset (async, rst=1):
  - State goes to IDLE; bitmap is cleared; occupancy=0.
  - All outputs are 0, except full=0 and cmd_ready=0.
  - Reset mid-operation abandons the command and its response. No further cam_write_enable is issued.
- FSM states: IDLE, LOOKUP, WRITE, WRITE_WAIT, RESP.
- IDLE:
  - cmd_ready = cam_setup & ~rsp_valid.
  - On accept in cycle T: latch op, key and mask; register cam_compare_data <= cmd_key (valid from T+1).
  - op 00/01/10 go to LOOKUP.
  - op 11 goes straight to RESP with BAD_OP (rsp_valid at T+1); there is no CAM access.
- LOOKUP:
  - A down-counter holds the FSM for MATCH_LATENCY cycles.
  - cam_match and cam_match_addr are sampled in cycle T+MATCH_LATENCY.
  - Lookup, hit or miss: go to RESP. Miss gives NOT_FOUND, hit=0.
  - Insert, hit: go to RESP with OK, hit=1, rsp_addr = existing address. No duplicate write.
  - Insert, miss while full: go to RESP with FULL.
  - Insert, miss while not full: alloc = lowest-index clear bitmap bit; go to WRITE.
  - Delete, miss: go to RESP with NOT_FOUND.
  - Delete, hit: target = matched address; go to WRITE with delete=1.
- WRITE:
  - Waits while cam_write_busy=1.
  - Then pulses cam_write_enable for exactly one cycle with addr, data=key, mask and delete all stable.
  - Goes to WRITE_WAIT.
- WRITE_WAIT:
  - Always spends at least 1 cycle here; the CAM raises busy the cycle after enable.
  - Exits on the first cycle with cam_write_busy=0.
  - On exit: set or clear the bitmap bit, update occupancy (+1 insert, -1 delete), go to RESP with OK. Insert gives hit=0; delete gives hit=1. rsp_addr = written address.
- RESP:
  - rsp_valid=1; all rsp_* fields stay stable until rsp_ready.
  - Return to IDLE the cycle after the handshake; rsp_* fields return to 0.
- Latency with rsp_ready=1:
  - Lookup: rsp_valid at T+MATCH_LATENCY+1.
  - Insert/delete: rsp_valid at T+MATCH_LATENCY+4 when the CAM is busy for exactly 1 cycle.
- Only one command is ever in flight. cmd_ready stays 0 in every state except IDLE.
- When cam_setup=0 in IDLE: cmd_ready=0 and pending commands stall. cam_setup is ignored once a command has been accepted.
- occupancy never wraps; full is derived combinationally from occupancy.
- cam_write_enable is never asserted outside WRITE.

Test Plan:
- Reset, cam_setup=1; insert key 0x1234 -> one cam_write_enable, addr=0, delete=0; rsp OK, hit=0, addr=0; occupancy=1.
- Lookup 0x1234, rsp_ready=1 -> rsp_valid exactly 3 cycles after accept (MATCH_LATENCY=2); hit=1, addr=0, OK. Lookup 0x5678 -> NOT_FOUND, hit=0.
- Insert 32 distinct keys, then a 33rd new key -> addresses 0..31 in order, full=1; 33rd gives FULL with no write pulse. Re-inserting an existing key while full gives OK, hit=1.
- Delete the key at addr 5, then insert a new key -> delete write at addr 5 with delete=1, occupancy 31; new key allocated addr 5, occupancy 32. Deleting an absent key gives NOT_FOUND.
- Hold cam_write_busy high 4 cycles before and 3 cycles after the enable -> enable waits for busy low and is exactly 1 cycle; response only after busy drops. Hold rsp_ready=0 for 5 cycles -> rsp fields stable and cmd_ready=0 throughout.
- op=11 -> BAD_OP at T+1 with no CAM activity. cam_setup=0 -> cmd_ready=0. Assert rst during WRITE_WAIT -> all outputs 0 immediately and occupancy 0.
